mcu_stream_writer: RTL and testbench
====================================

Name: mcu_stream_writer

Overview:
- Write-side counterpart of the MCU slot selector. It takes a serial stream of 32-bit samples over a valid/ready handshake and assembles each group of 64 samples into one 8x8 MCU.
- Each completed MCU is committed to the MCU slot bank as a single-beat write, with an 11-bit slot index that matches the selector's sel encoding.
- Slot index runs 0..NUM_MCU-1, then wraps. A frame_done pulse marks each full bank.

Parameters:
- NUM_MCU, 28, number of MCU slots in the bank; legal range 1..2047.
- SEL_W, 11, width of the slot index; must equal the selector's sel width.
- DATA_W, 32, width of one MCU element.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft restart; aborts the current MCU and sets the slot index to 0.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample.
- s_data  in  DATA_W  input sample.
- wr_valid  out  1  assembled MCU is presented for commit.
- wr_ready  in  1  slot bank accepts the commit.
- wr_slot  out  SEL_W  destination slot index.
- wr_mcu  out  8x8xDATA_W packed ([7:0][7:0][DATA_W-1:0])  assembled MCU, indexed [row][col].
- frame_done  out  1  one-cycle pulse after the commit of slot NUM_MCU-1.
- busy  out  1  high while an MCU is partially filled or a commit is pending.

Behaviour:
- Reset (rst_n=0, async): state=FILL, sample count k=0, slot=0, all outputs 0, local MCU buffer cleared to 0. Outputs are at 0 in this reset state:
  - s_ready, wr_valid, wr_slot, frame_done, busy.
  - s_ready rises on the first clk edge after rst_n deasserts.
- State FILL:
  - s_ready=1.
  - On s_valid&&s_ready, s_data is written into buffer[row][col] and k increments.
  - Raster mapping: row=k[5:3], col=k[2:0].
  - On the accept with k==63: k wraps to 0 and the next state is COMMIT.
- State COMMIT:
  - s_ready=0, wr_valid=1.
  - wr_mcu=buffer and wr_slot=slot, both held stable until handshake.
  - On wr_valid&&wr_ready:
    - slot==NUM_MCU-1: slot←0 and frame_done=1 on the next cycle.
    - otherwise: slot←slot+1.
  - Next state after the handshake is FILL.
- Latency: wr_valid rises on the cycle after the 64th sample is accepted. Minimum period is 65 cycles per MCU.
- Buffer contents are not cleared between MCUs; every element is overwritten on each MCU.
- busy = (state==COMMIT) || (k!=0).
- clear (synchronous, highest priority after reset):
  - Forces state=FILL, k=0, slot=0, wr_valid=0, frame_done=0.
  - Any sample or commit handshake in that same cycle is discarded.
- s_valid while s_ready=0: the sample is not taken; the upstream must hold it.
- wr_ready while wr_valid=0: ignored.
- Reset mid-MCU or mid-commit: everything is lost; no partial commit is ever emitted.
- Slot arithmetic is SEL_W bits, unsigned. Wrap is compared against NUM_MCU-1, not 2^SEL_W-1.

Optional Feature:
- MCU_ZIGZAG_EN defined: input order is JPEG zigzag. Sample k is written to buffer[zz_row(k)][zz_col(k)] via the standard 64-entry zigzag table. Examples: k=0→[0][0], k=1→[0][1], k=2→[1][0], k=3→[2][0], k=63→[7][7].
- Not defined: raster mapping as above; no table is instantiated.
- The handshake, timing and slot logic are identical in both builds.

Decomposition:
- Package mcu_pkg:
  - typedef mcu_t (logic [7:0][7:0][31:0]).
  - localparams MCU_ELEMS=64 and NUM_MCU_DEFAULT=28.
  - State enum {FILL, COMMIT}.
  - Zigzag constant table (64 entries, each {row[2:0],col[2:0]}).
- One sub-module, mcu_zigzag_lut: combinational k[5:0]→{row,col}. It is instantiated only under MCU_ZIGZAG_EN.

Test Plan:
- Raster fill: stream s_data=k for k=0..63 with s_valid constant and wr_ready=1 → wr_valid rises at cycle 65, wr_slot=0, wr_mcu[3][5]=29, wr_mcu[7][7]=63.
- Back-pressure: hold wr_ready=0 for 10 cycles after wr_valid → wr_mcu/wr_slot stable, s_ready=0, s_valid samples not taken; release → slot becomes 1 and s_ready returns next cycle.
- Wrap: stream 28 MCUs (data=slot*64+k) → wr_slot sequence 0..27, frame_done single pulse after slot 27 commit, next commit has wr_slot=0.
- clear mid-MCU: after 20 samples assert clear with s_valid=1 → sample dropped, busy=0, next 64 samples commit to slot 0 with their values only.
- Async reset during COMMIT: drop rst_n while wr_valid=1 → wr_valid=0 immediately without clk, and all outputs are 0.
- MCU_ZIGZAG_EN build: stream s_data=k → wr_mcu[0][1]=1, [1][0]=2, [2][0]=3, [7][7]=63.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and constants for the MCU stream writer.
// The zigzag table is only referenced when MCU_ZIGZAG_EN is defined.
package mcu_pkg;

  localparam int unsigned MCU_ELEMS       = 64;
  localparam int unsigned NUM_MCU_DEFAULT = 28;

  typedef logic [7:0][7:0][31:0] mcu_t;

  typedef enum logic {FILL, COMMIT} state_e;

  // Entry k holds {row[2:0], col[2:0]} of the k-th zigzag sample.
  localparam logic [5:0] ZZ_TABLE [MCU_ELEMS] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/mcu_zigzag_lut.sv
// Combinational zigzag lookup: sample index -> {row, col} inside the 8x8 MCU.
module mcu_zigzag_lut
  import mcu_pkg::*;
(
  input  logic [5:0] k_i,
  output logic [5:0] pos_o
);

  assign pos_o = ZZ_TABLE[k_i];

endmodule

// File: rtl/mcu_stream_writer.sv
// Assembles 64 streamed samples into one 8x8 MCU and commits it to a slot bank.
// Define MCU_ZIGZAG_EN to fill the MCU in JPEG zigzag order instead of raster order.
module mcu_stream_writer
  import mcu_pkg::*;
#(
  parameter int unsigned NUM_MCU = NUM_MCU_DEFAULT,
  parameter int unsigned SEL_W   = 11,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_W-1:0]                s_data,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic [SEL_W-1:0]                 wr_slot,
  output logic [7:0][7:0][DATA_W-1:0]      wr_mcu,
  output logic                             frame_done,
  output logic                             busy
);

  localparam logic [SEL_W-1:0] LastSlot = SEL_W'(NUM_MCU - 1);
  localparam logic [5:0]       LastK    = 6'(MCU_ELEMS - 1);

  state_e                         state_q, state_d;
  logic [5:0]                     k_q, k_d;
  logic [SEL_W-1:0]               slot_q, slot_d;
  logic                           fd_q, fd_d;
  logic                           rdy_q;
  logic [7:0][7:0][DATA_W-1:0]    buf_q;
  logic [5:0]                     pos;
  logic                           wr_en;

`ifdef MCU_ZIGZAG_EN
  mcu_zigzag_lut u_zigzag (
    .k_i   (k_q),
    .pos_o (pos)
  );
`else
  assign pos = k_q;
`endif

  // rdy_q keeps s_ready low until the first edge after reset release.
  assign s_ready    = rdy_q && (state_q == FILL);
  assign wr_valid   = (state_q == COMMIT);
  assign wr_slot    = slot_q;
  assign wr_mcu     = buf_q;
  assign frame_done = fd_q;
  assign busy       = (state_q == COMMIT) || (k_q != 6'd0);
  assign wr_en      = !clear && s_valid && s_ready;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    slot_d  = slot_q;
    fd_d    = 1'b0;
    if (clear) begin
      state_d = FILL;
      k_d     = 6'd0;
      slot_d  = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (s_valid && s_ready) begin
            k_d = k_q + 6'd1;
            if (k_q == LastK) state_d = COMMIT;
          end
        end
        COMMIT: begin
          if (wr_ready) begin
            state_d = FILL;
            if (slot_q == LastSlot) begin
              slot_d = '0;
              fd_d   = 1'b1;
            end else begin
              slot_d = slot_q + SEL_W'(1);
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      k_q     <= 6'd0;
      slot_q  <= '0;
      fd_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      slot_q  <= slot_d;
      fd_q    <= fd_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else if (wr_en) begin
      buf_q[pos[5:3]][pos[2:0]] <= s_data;
    end
  end

endmodule

// File: tb/tb_mcu_stream_writer.sv
// Randomized and directed bench for mcu_stream_writer against a sample-queue reference model.
module tb_mcu_stream_writer;

  localparam int NUM = 28;

  logic                     clk, rst_n, clear, s_valid, s_ready, wr_valid, wr_ready;
  logic                     frame_done, busy;
  logic [31:0]              s_data;
  logic [10:0]              wr_slot;
  logic [7:0][7:0][31:0]    wr_mcu;

  mcu_stream_writer #(.NUM_MCU(NUM), .SEL_W(11), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_slot    (wr_slot),
    .wr_mcu     (wr_mcu),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: samples of the MCU in flight, commits since restart.
  int          zz [64];
  logic [31:0] m_buf [64];
  bit          m_started, m_pending, m_fd, last_acc;
  int          m_n, m_done, fd_seen;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int pos_of(input int n);
`ifdef MCU_ZIGZAG_EN
    return zz[n];
`else
    return n;
`endif
  endfunction

  task automatic mdl_reset();
    m_started = 0; m_pending = 0; m_fd = 0; m_n = 0; m_done = 0;
    for (int i = 0; i < 64; i++) m_buf[i] = '0;
  endtask

  // Wait for the falling edge and compare every output against the model.
  task automatic tick();
    int bad;
    int first;
    @(negedge clk);
    if (frame_done === 1'b1) fd_seen++;
    chk("s_ready", 64'(s_ready), 64'(m_started && !m_pending));
    chk("wr_valid", 64'(wr_valid), 64'(m_pending));
    chk("wr_slot", 64'(wr_slot), 64'(m_done % NUM));
    chk("busy", 64'(busy), 64'(m_pending || (m_n != 0)));
    chk("frame_done", 64'(frame_done), 64'(m_fd));
    if (m_pending) begin
      bad = 0; first = -1;
      for (int p = 0; p < 64; p++)
        if (wr_mcu[p/8][p%8] !== m_buf[p]) begin
          bad++;
          if (first < 0) first = p;
        end
      n_chk++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL wr_mcu: %0d elements differ, first [%0d][%0d] got %0d expected %0d",
                 bad, first / 8, first % 8, wr_mcu[first/8][first%8], m_buf[first]);
      end
    end
  endtask

  // Drive inputs for the coming rising edge and advance the model across it.
  task automatic drive(input bit sv, input logic [31:0] sd, input bit wr, input bit cl);
    s_valid = sv; s_data = sd; wr_ready = wr; clear = cl;
    last_acc = 0;
    m_fd = 0;
    if (cl) begin
      m_n = 0; m_pending = 0; m_done = 0;
    end else if (m_pending) begin
      if (wr) begin
        m_done++;
        m_pending = 0;
        if (m_done % NUM == 0) m_fd = 1;
      end
    end else if (m_started && sv) begin
      last_acc = 1;
      m_buf[pos_of(m_n)] = sd;
      m_n++;
      if (m_n == 64) begin
        m_n = 0;
        m_pending = 1;
      end
    end
    m_started = 1;
  endtask

  initial begin
    bit          cur_sv;
    logic [31:0] cur_d;
    int          k, row;
    // Zigzag order by walking anti-diagonals, alternating direction.
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      for (int i = 0; i <= hi - lo; i++) begin
        row = (s % 2 == 0) ? hi - i : lo + i;
        zz[k] = row * 8 + (s - row);
        k++;
      end
    end

    rst_n = 1'b0; clear = 0; s_valid = 0; s_data = '0; wr_ready = 0;
    fd_seen = 0; last_acc = 0;
    mdl_reset();
    #12;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_wr_slot", 64'(wr_slot), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0);

    // Raster/zigzag fill with s_data=k; wr_valid shows up on the 65th cycle.
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 63) chk("wr_valid_before_65", 64'(wr_valid), 64'd0);
      drive(1, 32'(i), 1, 0);
    end
    tick();
    chk("fill_wr_valid_65", 64'(wr_valid), 64'd1);
    chk("fill_wr_slot", 64'(wr_slot), 64'd0);
    chk("fill_mcu77", 64'(wr_mcu[7][7]), 64'd63);
`ifdef MCU_ZIGZAG_EN
    chk("zz_mcu01", 64'(wr_mcu[0][1]), 64'd1);
    chk("zz_mcu10", 64'(wr_mcu[1][0]), 64'd2);
    chk("zz_mcu20", 64'(wr_mcu[2][0]), 64'd3);
`else
    chk("raster_mcu35", 64'(wr_mcu[3][5]), 64'd29);
    chk("raster_mcu01", 64'(wr_mcu[0][1]), 64'd1);
`endif

    // Back-pressure: ten cycles of wr_ready=0 with s_valid held high.
    drive(1, 777, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("bp_slot", 64'(wr_slot), 64'd0);
      chk("bp_s_ready", 64'(s_ready), 64'd0);
      chk("bp_mcu77", 64'(wr_mcu[7][7]), 64'd63);
      drive(1, 777, 0, 0);
    end
    tick();
    drive(1, 777, 1, 0);
    tick();
    chk("bp_release_slot", 64'(wr_slot), 64'd1);
    chk("bp_release_ready", 64'(s_ready), 64'd1);
    chk("bp_release_busy", 64'(busy), 64'd0);
    drive(0, 0, 0, 1);

    // Wrap across the whole bank.
    tick();
    fd_seen = 0;
    for (int m = 0; m < NUM; m++) begin
      for (int i = 0; i < 64; i++) begin
        tick();
        drive(1, 32'(m * 64 + i), 1, 0);
      end
      tick();
      chk("wrap_slot", 64'(wr_slot), 64'(m));
      drive(0, 0, 1, 0);
    end
    tick();
    chk("wrap_frame_done", 64'(frame_done), 64'd1);
    chk("wrap_slot_back_to_0", 64'(wr_slot), 64'd0);
    chk("wrap_fd_pulses", 64'(fd_seen), 64'd1);
    drive(0, 0, 0, 0);
    tick();
    chk("wrap_fd_single", 64'(frame_done), 64'd0);

    // clear after 20 samples, with a sample offered in the same cycle.
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      drive(1, 32'(2000 + i), 1, 0);
    end
    tick();
    drive(1, 999, 1, 1);
    tick();
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_slot", 64'(wr_slot), 64'd0);
    for (int i = 0; i < 64; i++) begin
      drive(1, 32'(1000 + i), 1, 0);
      tick();
    end
    chk("clr_commit_valid", 64'(wr_valid), 64'd1);
    chk("clr_commit_slot", 64'(wr_slot), 64'd0);
    chk("clr_mcu00", 64'(wr_mcu[0][0]), 64'd1000);
    chk("clr_mcu77", 64'(wr_mcu[7][7]), 64'd1063);
    drive(0, 0, 1, 0);

    // Randomized traffic; an unaccepted sample is held by the source.
    cur_sv = 0; cur_d = '0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!(cur_sv && !last_acc)) begin
        cur_sv = ($urandom_range(0, 3) != 0);
        cur_d  = $urandom;
      end
      drive(cur_sv, cur_d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
    end

    // Async reset while a commit is pending.
    tick();
    drive(0, 0, 0, 1);
    for (int i = 0; i < 200 && !m_pending; i++) begin
      tick();
      drive(1, $urandom, 0, 0);
    end
    tick();
    chk("ar_wr_valid_before", 64'(wr_valid), 64'd1);
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_wr_valid", 64'(wr_valid), 64'd0);
    chk("ar_s_ready", 64'(s_ready), 64'd0);
    chk("ar_slot", 64'(wr_slot), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_fd", 64'(frame_done), 64'd0);
    chk("ar_mcu", 64'(wr_mcu[7][7]), 64'd0);
    mdl_reset();
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
